jtkunio_gfxarb: RTL and testbench
=================================

# jtkunio_gfxarb

Graphics ROM arbiter for the Kunio video subsystem. It shares one SDRAM ROM read port between the char, scroll and object tile fetchers. It sits between those fetchers and the SDRAM controller port. Each requester gets a one-word hit buffer, so a repeated address answers immediately. Misses are serviced under fixed priority (char > scroll > object), with an object anti-starvation guard.

## Interface
Parameters:
- AW, 20, shared ROM word-address width
- CHAR_OFFSET, 20'h00000, base added to char_addr
- SCR_OFFSET, 20'h04000, base added to scr_addr
- OBJ_OFFSET, 20'h24000, base added to obj_addr
- OBJ_MAX, 4, grants object may lose while pending before it is forced next

Ports:
- clk  in  1  system clock; single clock domain
- rst  in  1  reset, asynchronous, active-high
- char_cs, char_addr[13:0], char_ok, char_data[31:0]  in/in/out/out  char requester
- scr_cs, scr_addr[16:0], scr_ok, scr_data[31:0]  in/in/out/out  scroll requester
- obj_cs, obj_addr[17:0], obj_ok, obj_data[31:0]  in/in/out/out  object requester
- rom_cs  out  1  shared port request
- rom_addr  out  AW  shared word address = offset + requester address, zero-extended, modulo 2^AW
- rom_ok  in  1  data valid from SDRAM
- rom_data  in  32  read data

## Operation
- Requester n has three registers: `last_n` (the address), `valid_n`, and `data_n` (32 bit).
- `hit_n = cs_n & valid_n & (addr_n == last_n)`.
- `x_ok = hit_n`. This is combinational from registers and inputs.
- `x_data = data_n` at all times.
- `pend_n = cs_n & ~hit_n`.
- The FSM has two states.
  - IDLE: `rom_cs` = 0.
    - If any pend is set, select a winner.
    - Normal winner order is char, then scr, then obj.
    - If `obj_skip == OBJ_MAX` and obj pend is set, obj wins instead.
    - Latch owner, requester address (`lat_addr`) and `rom_addr`; go to BUSY.
  - BUSY: `rom_cs` = 1 and `rom_addr` is held stable.
    - `rom_ok` is ignored in the first BUSY cycle, so a stale ok from the previous access is not accepted.
    - From the second cycle on, `rom_ok` = 1 writes `data_n <= rom_data`, `last_n <= lat_addr` and `valid_n <= 1` for the owner, then returns to IDLE.
- `obj_skip` (3 bit, saturating at OBJ_MAX):
  - increments on every grant to char or scr while obj pend = 1;
  - clears on an obj grant;
  - holds when obj is not pending.
- Address change during BUSY: the access still completes and fills with `lat_addr`. The mismatch then gives a miss, which re-requests.
- `cs_n` low during BUSY: the access still completes and the buffer is written. `ok_n` stays 0 while cs is low.
- A requester whose address matches its buffer never occupies the port.
- There is no timeout. BUSY waits indefinitely for `rom_ok`.

## Timing
- Reset (asynchronous, immediate):
  - state IDLE, `rom_cs` = 0, `rom_addr` = 0;
  - all `valid` = 0, `last` = 0, `data` = 0;
  - `obj_skip` = 0;
  - hence `char_ok`/`scr_ok`/`obj_ok` = 0 and all data outputs = 0.
- Reset mid-BUSY aborts the access: `rom_cs` drops asynchronously and no buffer is written.
- Miss latency: the address changes at edge E. Pend is seen in IDLE, and `rom_cs` = 1 from edge E+1. If `rom_ok` arrives in the second BUSY cycle, data and valid update at E+3 and `x_ok` is high after E+3.
- Hit latency: zero cycles. `ok` follows the address compare combinationally.
- Back-to-back grants always have exactly one IDLE cycle (`rom_cs` = 0) between them.
- Simultaneous pends are resolved in a single IDLE cycle. Losers keep pending and are evaluated again at the next IDLE.

## Test plan
- Reset: assert rst with `char_cs` = 1 and `char_addr` = 0. Required: `char_ok` = 0, `rom_cs` = 0, `rom_addr` = 0.
- Single miss, then hit:
  - `char_addr` = 14'h0123, memory model answers ok on the second BUSY cycle.
  - Required: `rom_addr` = 20'h00123, `char_data` = model word, `char_ok` high 3 cycles after the address change.
  - Re-present 14'h0123: `char_ok` high with no new `rom_cs`.
- Offsets: `scr_addr` = 17'h00010 → `rom_addr` = 20'h04010. `obj_addr` = 18'h00010 → `rom_addr` = 20'h24010.
- Stale ok: hold `rom_ok` = 1 continuously. Each grant must still last 2 cycles, and the correct data must be latched per owner.
- Priority and starvation:
  - char, scr and obj all miss continuously with changing addresses.
  - Required: obj is granted no later than after 4 char/scr grants, and `obj_skip` clears after the obj grant.
- Address change and reset mid-BUSY:
  - Change `char_addr` during BUSY. Required: the fill completes, `char_ok` stays 0, and a second access is issued for the new address.
  - Assert rst during BUSY. Required: `rom_cs` falls without waiting for a clock edge, and `valid` stays 0.

Source files
------------

// File: rtl/jtkunio_gfxarb_if.sv
// Bus bundle for the Kunio graphics ROM arbiter: three tile fetchers on one
// side, the shared SDRAM ROM read port on the other.
interface jtkunio_gfxarb_if #(
    parameter int AW = 20
);
    logic        char_cs;
    logic [13:0] char_addr;
    logic        char_ok;
    logic [31:0] char_data;

    logic        scr_cs;
    logic [16:0] scr_addr;
    logic        scr_ok;
    logic [31:0] scr_data;

    logic        obj_cs;
    logic [17:0] obj_addr;
    logic        obj_ok;
    logic [31:0] obj_data;

    logic          rom_cs;
    logic [AW-1:0] rom_addr;
    logic          rom_ok;
    logic [31:0]   rom_data;

    // Arbiter side
    modport slave (
        input  char_cs, char_addr, scr_cs, scr_addr, obj_cs, obj_addr,
        input  rom_ok, rom_data,
        output char_ok, char_data, scr_ok, scr_data, obj_ok, obj_data,
        output rom_cs, rom_addr
    );

    // Fetchers plus SDRAM side
    modport master (
        output char_cs, char_addr, scr_cs, scr_addr, obj_cs, obj_addr,
        output rom_ok, rom_data,
        input  char_ok, char_data, scr_ok, scr_data, obj_ok, obj_data,
        input  rom_cs, rom_addr
    );
endinterface

// File: rtl/jtkunio_gfxarb.sv
// Kunio graphics ROM arbiter. Each fetcher owns a one-word hit buffer; misses
// go to the shared ROM port under fixed priority char > scr > obj, with obj
// forced through after OBJ_MAX lost grants.
//
// state | meaning
// IDLE  | rom_cs low, pick a winner among pending misses
// BUSY  | rom_cs high, rom_addr held, wait for rom_ok (ignored on 1st cycle)
module jtkunio_gfxarb #(
    parameter int            AW          = 20,
    parameter logic [AW-1:0] CHAR_OFFSET = 20'h00000,
    parameter logic [AW-1:0] SCR_OFFSET  = 20'h04000,
    parameter logic [AW-1:0] OBJ_OFFSET  = 20'h24000,
    parameter int            OBJ_MAX     = 4
) (
    input  logic             clk,
    input  logic             rst,
    jtkunio_gfxarb_if.slave  bus
);

    typedef enum logic { ST_IDLE, ST_BUSY } state_t;
    typedef enum logic [1:0] { OWN_CHAR, OWN_SCR, OWN_OBJ } owner_t;

    localparam logic [2:0] SKIP_MAX = 3'(OBJ_MAX);

    state_t        state_q,   state_d;
    owner_t        owner_q,   owner_d;
    logic          first_q,   first_d;
    logic          rom_cs_q,  rom_cs_d;
    logic [AW-1:0] rom_addr_q, rom_addr_d;
    logic [17:0]   lat_addr_q, lat_addr_d;
    logic [2:0]    obj_skip_q, obj_skip_d;

    logic          char_valid_q, char_valid_d;
    logic [13:0]   char_last_q,  char_last_d;
    logic [31:0]   char_data_q,  char_data_d;
    logic          scr_valid_q,  scr_valid_d;
    logic [16:0]   scr_last_q,   scr_last_d;
    logic [31:0]   scr_data_q,   scr_data_d;
    logic          obj_valid_q,  obj_valid_d;
    logic [17:0]   obj_last_q,   obj_last_d;
    logic [31:0]   obj_data_q,   obj_data_d;

    logic char_hit, scr_hit, obj_hit;
    logic char_pend, scr_pend, obj_pend;

    logic          grant;
    owner_t        win;
    logic [17:0]   win_addr;
    logic [AW-1:0] win_rom;

    // Hit detection is purely combinational so a repeated address answers at once
    always_comb begin
        char_hit  = bus.char_cs & char_valid_q & (bus.char_addr == char_last_q);
        scr_hit   = bus.scr_cs  & scr_valid_q  & (bus.scr_addr  == scr_last_q);
        obj_hit   = bus.obj_cs  & obj_valid_q  & (bus.obj_addr  == obj_last_q);
        char_pend = bus.char_cs & ~char_hit;
        scr_pend  = bus.scr_cs  & ~scr_hit;
        obj_pend  = bus.obj_cs  & ~obj_hit;
    end

    assign bus.char_ok   = char_hit;
    assign bus.scr_ok    = scr_hit;
    assign bus.obj_ok    = obj_hit;
    assign bus.char_data = char_data_q;
    assign bus.scr_data  = scr_data_q;
    assign bus.obj_data  = obj_data_q;
    assign bus.rom_cs    = rom_cs_q;
    assign bus.rom_addr  = rom_addr_q;

    // Winner selection: starved obj first, otherwise char > scr > obj
    always_comb begin
        grant    = 1'b0;
        win      = OWN_CHAR;
        win_addr = '0;
        win_rom  = '0;
        if (obj_pend && (obj_skip_q == SKIP_MAX)) begin
            grant    = 1'b1;
            win      = OWN_OBJ;
            win_addr = bus.obj_addr;
            win_rom  = OBJ_OFFSET + AW'(bus.obj_addr);
        end else if (char_pend) begin
            grant    = 1'b1;
            win      = OWN_CHAR;
            win_addr = 18'(bus.char_addr);
            win_rom  = CHAR_OFFSET + AW'(bus.char_addr);
        end else if (scr_pend) begin
            grant    = 1'b1;
            win      = OWN_SCR;
            win_addr = 18'(bus.scr_addr);
            win_rom  = SCR_OFFSET + AW'(bus.scr_addr);
        end else if (obj_pend) begin
            grant    = 1'b1;
            win      = OWN_OBJ;
            win_addr = bus.obj_addr;
            win_rom  = OBJ_OFFSET + AW'(bus.obj_addr);
        end
    end

    // Next-state for the FSM, the anti-starvation counter and the hit buffers
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        first_d      = first_q;
        rom_cs_d     = rom_cs_q;
        rom_addr_d   = rom_addr_q;
        lat_addr_d   = lat_addr_q;
        obj_skip_d   = obj_skip_q;
        char_valid_d = char_valid_q;
        char_last_d  = char_last_q;
        char_data_d  = char_data_q;
        scr_valid_d  = scr_valid_q;
        scr_last_d   = scr_last_q;
        scr_data_d   = scr_data_q;
        obj_valid_d  = obj_valid_q;
        obj_last_d   = obj_last_q;
        obj_data_d   = obj_data_q;

        case (state_q)
            ST_IDLE: begin
                if (grant) begin
                    state_d    = ST_BUSY;
                    owner_d    = win;
                    first_d    = 1'b1;
                    rom_cs_d   = 1'b1;
                    rom_addr_d = win_rom;
                    lat_addr_d = win_addr;
                    if (win == OWN_OBJ) begin
                        obj_skip_d = '0;
                    end else if (obj_pend && (obj_skip_q != SKIP_MAX)) begin
                        obj_skip_d = obj_skip_q + 3'd1;
                    end
                end
            end
            ST_BUSY: begin
                first_d = 1'b0;
                // The first BUSY cycle may still see the previous access's ok
                if (!first_q && bus.rom_ok) begin
                    state_d  = ST_IDLE;
                    rom_cs_d = 1'b0;
                    case (owner_q)
                        OWN_CHAR: begin
                            char_valid_d = 1'b1;
                            char_last_d  = lat_addr_q[13:0];
                            char_data_d  = bus.rom_data;
                        end
                        OWN_SCR: begin
                            scr_valid_d = 1'b1;
                            scr_last_d  = lat_addr_q[16:0];
                            scr_data_d  = bus.rom_data;
                        end
                        default: begin
                            obj_valid_d = 1'b1;
                            obj_last_d  = lat_addr_q;
                            obj_data_d  = bus.rom_data;
                        end
                    endcase
                end
            end
            default: begin
                state_d  = ST_IDLE;
                rom_cs_d = 1'b0;
            end
        endcase
    end

    // All state; async reset aborts any access and empties every buffer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            owner_q      <= OWN_CHAR;
            first_q      <= 1'b0;
            rom_cs_q     <= 1'b0;
            rom_addr_q   <= '0;
            lat_addr_q   <= '0;
            obj_skip_q   <= '0;
            char_valid_q <= 1'b0;
            char_last_q  <= '0;
            char_data_q  <= '0;
            scr_valid_q  <= 1'b0;
            scr_last_q   <= '0;
            scr_data_q   <= '0;
            obj_valid_q  <= 1'b0;
            obj_last_q   <= '0;
            obj_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            first_q      <= first_d;
            rom_cs_q     <= rom_cs_d;
            rom_addr_q   <= rom_addr_d;
            lat_addr_q   <= lat_addr_d;
            obj_skip_q   <= obj_skip_d;
            char_valid_q <= char_valid_d;
            char_last_q  <= char_last_d;
            char_data_q  <= char_data_d;
            scr_valid_q  <= scr_valid_d;
            scr_last_q   <= scr_last_d;
            scr_data_q   <= scr_data_d;
            obj_valid_q  <= obj_valid_d;
            obj_last_q   <= obj_last_d;
            obj_data_q   <= obj_data_d;
        end
    end

endmodule

// File: tb/tb_jtkunio_gfxarb.sv
// Bench for jtkunio_gfxarb: transaction-level reference model, grant scoreboard
// and a small SDRAM responder, with directed cases followed by random traffic.
module tb_jtkunio_gfxarb;
    localparam int AW      = 20;
    localparam int OBJ_MAX = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    jtkunio_gfxarb_if #(.AW(AW)) bus ();
    jtkunio_gfxarb #(.AW(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
        return (32'(a) * 32'h9E3779B1) ^ 32'hC3A5_0F1E;
    endfunction

    // SDRAM responder: 0 = ok on 2nd BUSY cycle, 1 = ok stuck high, 2 = random ok
    int rmode = 0;
    int rcnt  = 0;
    initial begin
        bus.rom_ok   = 1'b0;
        bus.rom_data = '0;
        forever begin
            @(posedge clk); #1;
            if (bus.rom_cs) rcnt++; else rcnt = 0;
            case (rmode)
                0:       bus.rom_ok = (rcnt == 2);
                1:       bus.rom_ok = 1'b1;
                default: bus.rom_ok = ($urandom_range(0, 2) == 0);
            endcase
            bus.rom_data = mem_word(bus.rom_addr);
        end
    end

    // Reference model: buffers per requester, one outstanding ROM access
    logic [AW-1:0] off [3] = '{20'h00000, 20'h04000, 20'h24000};
    bit            m_valid [3];
    logic [17:0]   m_last  [3];
    logic [31:0]   m_data  [3];
    bit            m_busy;
    int            m_own, m_cnt, m_skip;
    logic [17:0]   m_lat;
    logic [AW-1:0] m_rom_addr;
    logic [AW-1:0] grant_q [$];

    bit          cs   [3];
    logic [17:0] addr [3];
    bit          hit  [3];
    bit          pend [3];

    initial begin
        forever begin
            @(negedge clk);
            cs[0] = bus.char_cs; addr[0] = 18'(bus.char_addr);
            cs[1] = bus.scr_cs;  addr[1] = 18'(bus.scr_addr);
            cs[2] = bus.obj_cs;  addr[2] = bus.obj_addr;
            if (rst) begin
                for (int i = 0; i < 3; i++) begin
                    m_valid[i] = 0; m_last[i] = '0; m_data[i] = '0;
                end
                m_busy = 0; m_cnt = 0; m_skip = 0; m_rom_addr = '0; m_own = 0; m_lat = '0;
                grant_q.delete();
            end
            for (int i = 0; i < 3; i++) begin
                hit[i]  = cs[i] && m_valid[i] && (addr[i] == m_last[i]);
                pend[i] = cs[i] && !hit[i];
            end
            check("char_ok",   bus.char_ok,   hit[0]);
            check("scr_ok",    bus.scr_ok,    hit[1]);
            check("obj_ok",    bus.obj_ok,    hit[2]);
            check("char_data", bus.char_data, m_data[0]);
            check("scr_data",  bus.scr_data,  m_data[1]);
            check("obj_data",  bus.obj_data,  m_data[2]);
            check("rom_cs",    bus.rom_cs,    m_busy);
            check("rom_addr",  bus.rom_addr,  m_rom_addr);
            check("obj_skip",  dut.obj_skip_q, m_skip);
            if (!rst) begin
                if (!m_busy) begin
                    int w;
                    w = -1;
                    if (pend[2] && m_skip == OBJ_MAX) w = 2;
                    else begin
                        for (int i = 2; i >= 0; i--) if (pend[i]) w = i;
                    end
                    if (w >= 0) begin
                        if (w == 2) m_skip = 0;
                        else if (pend[2] && m_skip < OBJ_MAX) m_skip++;
                        m_busy     = 1;
                        m_own      = w;
                        m_cnt      = 0;
                        m_lat      = addr[w];
                        m_rom_addr = off[w] + AW'(addr[w]);
                        grant_q.push_back(m_rom_addr);
                    end
                end else begin
                    if (m_cnt >= 1 && bus.rom_ok) begin
                        m_valid[m_own] = 1;
                        m_last[m_own]  = m_lat;
                        m_data[m_own]  = mem_word(m_rom_addr);
                        m_busy         = 0;
                    end
                    m_cnt++;
                end
            end
        end
    end

    // Grant monitor: pops expected addresses on each new rom_cs and checks
    // busy length and the obj anti-starvation bound from the DUT's own pins
    bit prev_cs = 0;
    bit prev_obj_pend = 0;
    int busy_len = 0;
    int gmode = 0;
    int streak = 0;
    int obj_grants = 0;
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                streak   = 0;
                busy_len = 0;
            end else if (bus.rom_cs && !prev_cs) begin
                if (grant_q.size() == 0) begin
                    check("grant_expected", 0, 1);
                end else begin
                    check("grant_addr", bus.rom_addr, grant_q.pop_front());
                end
                if (bus.rom_addr >= 20'h24000) begin
                    streak = 0;
                    obj_grants++;
                end else if (prev_obj_pend) begin
                    streak++;
                    check("obj_starve", (streak <= OBJ_MAX), 1);
                end
                busy_len = 1;
                gmode    = rmode;
            end else if (bus.rom_cs) begin
                busy_len++;
            end else if (prev_cs) begin
                if (gmode == 1) check("busy_len_stale", busy_len, 2);
                else            check("busy_len_min", (busy_len >= 2), 1);
            end
            prev_cs       = bus.rom_cs;
            prev_obj_pend = bus.obj_cs && !bus.obj_ok;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic rand_phase(input int cycles, input int mode, input bit starve);
        rmode = mode;
        repeat (cycles) begin
            tick(1);
            if (starve) begin
                bus.char_cs = 1; bus.scr_cs = 1; bus.obj_cs = 1;
                bus.char_addr = 14'($urandom);
                bus.scr_addr  = 17'($urandom);
                bus.obj_addr  = 18'($urandom);
            end else begin
                if ($urandom_range(0, 3) == 0) bus.char_cs = ~bus.char_cs;
                if ($urandom_range(0, 3) == 0) bus.scr_cs  = ~bus.scr_cs;
                if ($urandom_range(0, 3) == 0) bus.obj_cs  = ~bus.obj_cs;
                if ($urandom_range(0, 2) == 0) bus.char_addr = 14'($urandom_range(0, 3));
                if ($urandom_range(0, 2) == 0) bus.scr_addr  = 17'($urandom_range(0, 3));
                if ($urandom_range(0, 2) == 0) bus.obj_addr  = ($urandom_range(0, 7) == 0) ?
                                                               18'($urandom) : 18'($urandom_range(0, 3));
            end
        end
    endtask

    initial begin
        int g0;
        bus.char_cs = 1; bus.char_addr = '0;
        bus.scr_cs  = 0; bus.scr_addr  = '0;
        bus.obj_cs  = 0; bus.obj_addr  = '0;
        rst = 1;
        tick(3);
        check("rst_char_ok",  bus.char_ok,  0);
        check("rst_rom_cs",   bus.rom_cs,   0);
        check("rst_rom_addr", bus.rom_addr, 0);
        rst = 0;
        tick(6);

        // single miss then hit
        bus.char_addr = 14'h0123;
        tick(1);
        check("miss_rom_cs",   bus.rom_cs,   1);
        check("miss_rom_addr", bus.rom_addr, 20'h00123);
        tick(1);
        check("miss_ok_early", bus.char_ok, 0);
        tick(1);
        check("miss_ok_e3",   bus.char_ok,   1);
        check("miss_data_e3", bus.char_data, mem_word(20'h00123));
        bus.char_cs = 0;
        tick(1);
        bus.char_cs = 1;
        #1 check("rehit_ok", bus.char_ok, 1);
        for (int i = 0; i < 3; i++) begin
            tick(1);
            check("rehit_no_rom_cs", bus.rom_cs, 0);
        end
        bus.char_cs = 0;

        // offsets
        bus.scr_cs = 1; bus.scr_addr = 17'h00010;
        tick(1);
        check("scr_offset", bus.rom_addr, 20'h04010);
        tick(3);
        bus.scr_cs = 0;
        bus.obj_cs = 1; bus.obj_addr = 18'h00010;
        tick(1);
        check("obj_offset", bus.rom_addr, 20'h24010);
        tick(2);
        check("obj_fill_data", bus.obj_data, mem_word(20'h24010));
        tick(1);

        // obj cs dropped during BUSY: buffer still written
        bus.obj_addr = 18'h00033;
        tick(1);
        bus.obj_cs = 0;
        tick(2);
        check("cs_low_ok", bus.obj_ok, 0);
        tick(1);
        bus.obj_cs = 1;
        #1 check("cs_low_filled", bus.obj_ok, 1);
        bus.obj_cs = 0;
        tick(2);

        // char address change during BUSY
        bus.char_cs = 1; bus.char_addr = 14'h0200;
        tick(1);
        bus.char_addr = 14'h0201;
        tick(2);
        check("chg_ok_after_fill", bus.char_ok, 0);
        tick(1);
        check("chg_reissue_cs",   bus.rom_cs,   1);
        check("chg_reissue_addr", bus.rom_addr, 20'h00201);
        tick(2);
        check("chg_final_ok", bus.char_ok, 1);

        // reset in the middle of BUSY
        bus.char_addr = 14'h0300;
        tick(1);
        check("rstb_busy", bus.rom_cs, 1);
        #2 rst = 1;
        #1 check("rstb_async_drop", bus.rom_cs, 0);
        tick(2);
        rst = 0;
        #1 check("rstb_valid_clear", bus.char_ok, 0);
        bus.char_cs = 0;
        tick(5);

        rand_phase(2500, 2, 0);
        rand_phase(800,  1, 0);
        g0 = obj_grants;
        rand_phase(800,  0, 1);
        check("starve_obj_granted", (obj_grants > g0), 1);
        rand_phase(1500, 2, 0);

        bus.char_cs = 0; bus.scr_cs = 0; bus.obj_cs = 0;
        rmode = 0;
        tick(12);
        check("drain_rom_cs", bus.rom_cs, 0);
        check("drain_queue", grant_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end
endmodule
